// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg: state encoding and byte-enable width helper shared by ram_burst_master
// and its read FIFO.
package ram_burst_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
   function automatic int byte_enw(input int dw, input logic [23:0] byte_wr_en);
      return (byte_wr_en == "YES") ? dw / 8 : 1;
   endfunction
endpackage

// File: rtl/ram_rd_skid_fifo.sv
// ram_rd_skid_fifo: 2-entry read-data FIFO; a push may coincide with a pop while full.
module ram_rd_skid_fifo #(
   parameter int Dw = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [Dw-1:0] din,
   input  logic          pop,
   output logic [Dw-1:0] dout,
   output logic [1:0]    count
);
   logic [Dw-1:0] mem [2];
   logic          wr_ptr, rd_ptr;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master: valid/ready burst commands to single-port RAM cycles with a backpressured
// read stream. RAM_BURST_MASTER_STAT_EN adds saturating write/read beat counters.
module ram_burst_master
   import ram_burst_pkg::*;
#(
   parameter int Dw         = 32,
   parameter int Aw         = 10,
   parameter     BYTE_WR_EN = "YES",
   parameter int BLw        = 8,
   localparam int BYTE_ENw  = byte_enw(Dw, BYTE_WR_EN)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_we,
   input  logic [Aw-1:0]       cmd_addr,
   input  logic [BLw-1:0]      cmd_len,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [Dw-1:0]       wr_data,
   input  logic [BYTE_ENw-1:0] wr_be,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [Dw-1:0]       rd_data,
   output logic                busy,
   output logic [Dw-1:0]       ram_data,
   output logic [Aw-1:0]       ram_addr,
   output logic [BYTE_ENw-1:0] ram_byteen,
   output logic                ram_we,
`ifdef RAM_BURST_MASTER_STAT_EN
   input  logic [Dw-1:0]       ram_q,
   output logic [31:0]         stat_wr_beats,
   output logic [31:0]         stat_rd_beats
`else
   input  logic [Dw-1:0]       ram_q
`endif
);
   state_t         state;
   logic [Aw-1:0]  addr;
   logic [BLw-1:0] cnt;
   logic           inflight, issue, pop, wr_beat;
   logic [1:0]     fcount;
   logic [2:0]     free;

   assign cmd_ready  = state == IDLE;
   assign wr_ready   = state == WRITE;
   assign wr_beat    = wr_ready & wr_valid;
   assign pop        = rd_valid & rd_ready;
   // a read may only issue if its capture is guaranteed a FIFO slot
   assign free       = 3'd2 - {1'b0, fcount} + {2'b0, pop};
   assign issue      = state == READ && free > {2'b0, inflight};
   assign rd_valid   = fcount != 2'd0;
   assign busy       = state != IDLE || inflight || rd_valid;
   assign ram_we     = wr_beat;
   assign ram_addr   = addr;
   assign ram_data   = wr_ready ? wr_data : '0;
   assign ram_byteen = !wr_ready ? '0 : (BYTE_WR_EN == "YES") ? wr_be : '1;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         addr     <= '0;
         cnt      <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         case (state)
            IDLE:
               if (cmd_valid) begin
                  addr  <= cmd_addr;
                  cnt   <= cmd_len;
                  state <= cmd_we ? WRITE : READ;
               end
            default:
               if (wr_beat || issue) begin
                  addr <= addr + 1'b1;
                  cnt  <= cnt - 1'b1;
                  if (cnt == '0) state <= IDLE;
               end
         endcase
      end

   ram_rd_skid_fifo #(.Dw(Dw)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight),
      .din   (ram_q),
      .pop   (pop),
      .dout  (rd_data),
      .count (fcount)
   );

`ifdef RAM_BURST_MASTER_STAT_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         stat_wr_beats <= '0;
         stat_rd_beats <= '0;
      end else begin
         if (ram_we && stat_wr_beats != '1) stat_wr_beats <= stat_wr_beats + 32'd1;
         if (pop && stat_rd_beats != '1) stat_rd_beats <= stat_rd_beats + 32'd1;
      end
`endif
endmodule
